// File: rtl/fifo_nibble_uart_tx.sv
// Drains a nibble FIFO and pairs the nibbles into bytes, low nibble first.
// Each byte is sent LSB first as a UART 8N1 frame on tx.
module fifo_nibble_uart_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [7:0]       frame_cnt
);

  localparam int BW = 2 * WIDTH;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_HI, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [BW-1:0]   r_byte;
  logic            r_rd_q;
  logic            r_tx;
  logic            r_tx_done;
  logic [7:0]      r_frame_cnt;
  logic            w_bit_end;
  logic            w_tx_nxt;

  assign w_bit_end = (r_timer == TW'(CLKS_PER_BIT - 1));

  // rd_q blocks a second pop until the FIFO's empty flag has caught up.
  assign fifo_rd   = rst_n && (r_state == S_IDLE || r_state == S_WAIT_HI) &&
                     !fifo_empty && !r_rd_q;
  assign busy      = (r_state != S_IDLE);
  assign tx        = r_tx;
  assign tx_done   = r_tx_done;
  assign frame_cnt = r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE:    if (fifo_rd) w_state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (fifo_rd) w_state_nxt = S_START;
      S_START: if (w_bit_end) begin
        w_state_nxt = S_DATA;
        w_idx_nxt   = '0;
      end
      S_DATA: if (w_bit_end) begin
        if (r_idx == IW'(BW - 1)) w_state_nxt = S_STOP;
        else                      w_idx_nxt   = r_idx + IW'(1);
      end
      S_STOP:  if (w_bit_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // tx is registered from the next state so the start bit appears the cycle after the high pop.
  always_comb begin
    w_tx_nxt = 1'b1;
    if (w_state_nxt == S_START)     w_tx_nxt = 1'b0;
    else if (w_state_nxt == S_DATA) w_tx_nxt = r_byte[w_idx_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_idx       <= '0;
      r_byte      <= '0;
      r_rd_q      <= 1'b0;
      r_tx        <= 1'b1;
      r_tx_done   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_rd_q    <= fifo_rd;
      r_tx      <= w_tx_nxt;
      r_idx     <= w_idx_nxt;
      r_tx_done <= 1'b0;
      if ((r_state == S_START || r_state == S_DATA || r_state == S_STOP) && !w_bit_end)
        r_timer <= r_timer + TW'(1);
      else
        r_timer <= '0;
      if (fifo_rd && r_state == S_IDLE)    r_byte[WIDTH-1:0]  <= fifo_rdata;
      if (fifo_rd && r_state == S_WAIT_HI) r_byte[BW-1:WIDTH] <= fifo_rdata;
      if (r_state == S_STOP && w_bit_end) begin
        r_tx_done   <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_nibble_uart_tx.sv
// Bench for fifo_nibble_uart_tx: show-ahead FIFO model, timing-level frame model
// compared every cycle, a UART decoder, and directed scenarios with literal expectations.
module tb_fifo_nibble_uart_tx;
  localparam int W   = 4;
  localparam int CPB = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_rdata = '0;
  logic         fifo_rd, tx, busy, tx_done;
  logic [7:0]   frame_cnt;

  fifo_nibble_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Show-ahead FIFO: flag and head data update on the edge after a push or pop.
  logic [W-1:0] fq[$];
  logic [W-1:0] push_q[$];
  always @(posedge clk) begin
    if (fifo_rd) begin
      check("pop_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) void'(fq.pop_front());
    end
    while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    fifo_empty <= (fq.size() == 0);
    fifo_rdata <= (fq.size() != 0) ? fq[0] : '0;
  end

  // Frame model: a frame occupies 10*CPB cycles starting the cycle after the second pop.
  int         cyc = 0;
  bit         m_active, m_held, m_prev_rd;
  int         m_start;
  logic [7:0] m_byte, m_cnt;
  logic [W-1:0] m_lo;
  logic [9:0] m_frame;
  logic       e_tx, e_rd, e_busy, e_done;
  int         rd_total = 0, done_total = 0, last_rd_cyc = 0, cnt_at_256 = -1;

  bit         rx_act;
  int         rx_start, off, k;
  logic [7:0] rx_sh;
  logic       prev_tx = 1'b1;
  logic [7:0] rx_q[$];
  int         fall_q[$];
  logic       bits_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_cnt", 32'(frame_cnt), 32'd0);
      m_active = 0; m_held = 0; m_prev_rd = 0; m_cnt = '0;
      rx_act = 0; prev_tx = 1'b1; done_total = 0;
    end else begin
      e_done = 1'b0;
      if (m_active && cyc == m_start + 10*CPB) begin
        m_active = 0; m_cnt = m_cnt + 8'd1; e_done = 1'b1;
      end
      m_frame = {1'b1, m_byte, 1'b0};
      e_tx   = m_active ? m_frame[(cyc - m_start) / CPB] : 1'b1;
      e_rd   = !m_active && !fifo_empty && !m_prev_rd;
      e_busy = m_active || m_held;
      check("tx", 32'(tx), 32'(e_tx));
      check("fifo_rd", 32'(fifo_rd), 32'(e_rd));
      check("busy", 32'(busy), 32'(e_busy));
      check("tx_done", 32'(tx_done), 32'(e_done));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      if (e_rd) begin
        if (!m_held) begin
          m_lo = fifo_rdata; m_held = 1;
        end else begin
          m_byte = {fifo_rdata, m_lo}; m_held = 0; m_active = 1; m_start = cyc + 1;
        end
      end
      m_prev_rd = e_rd;
      if (fifo_rd) begin rd_total++; last_rd_cyc = cyc; end
      if (tx_done) begin
        done_total++;
        if (done_total == 256) cnt_at_256 = int'(frame_cnt);
      end
      // Independent UART receiver sampling mid-bit.
      if (!rx_act) begin
        if (prev_tx && !tx) begin rx_act = 1; rx_start = cyc; fall_q.push_back(cyc); end
      end else begin
        off = cyc - rx_start;
        if (off % CPB == CPB/2) begin
          k = off / CPB;
          bits_q.push_back(tx);
          if (k >= 1 && k <= 8) rx_sh = {tx, rx_sh[7:1]};
          if (k == 9) begin rx_q.push_back(rx_sh); rx_act = 0; end
        end
      end
      prev_tx = tx;
    end
  end

  task automatic wait_frames(input int n);
    int t = 0;
    while (rx_q.size() < n && t < 20000) begin @(posedge clk); t++; end
    check("frames_seen", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic push(input logic [W-1:0] v);
    int t = 0;
    while (fq.size() + push_q.size() >= 8 && t < 5000) begin @(posedge clk); t++; end
    push_q.push_back(v);
  endtask

  logic [9:0] exp_bits;
  int rd0, t;
  logic [7:0] exp_b2b [4];

  initial begin
    exp_bits = 10'b1101001010;
    exp_b2b  = '{8'h21, 8'h43, 8'h65, 8'h87};
    // Reset with a non-empty FIFO: no pop may leave the block.
    push_q.push_back(4'h5);
    repeat (5) @(posedge clk);
    #1 check("rst_rd_literal", 32'(fifo_rd), 32'd0);
    check("rst_tx_literal", 32'(tx), 32'd1);
    rst_n = 1'b1;

    // Single frame 0xA5.
    push(4'hA);
    wait_frames(1);
    repeat (20) @(posedge clk);
    #1;
    check("single_byte", 32'(rx_q[0]), 32'hA5);
    for (int i = 0; i < 10; i++) check("single_bit", 32'(bits_q[i]), 32'(exp_bits[i]));
    check("single_rd_pulses", 32'(rd_total), 32'd2);
    check("single_done_pulses", 32'(done_total), 32'd1);
    check("single_frame_cnt", 32'(frame_cnt), 32'd1);

    // Odd nibble stall.
    push(4'h3);
    repeat (100) @(posedge clk);
    #1;
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_tx", 32'(tx), 32'd1);
    check("stall_no_start", 32'(fall_q.size()), 32'd1);
    push(4'hC);
    wait_frames(2);
    check("stall_byte", 32'(rx_q[1]), 32'hC3);
    check("stall_start_latency", 32'(fall_q[1] - last_rd_cyc), 32'd1);
    repeat (20) @(posedge clk);

    // Back-to-back frames from a full FIFO.
    rd0 = rd_total;
    for (int i = 1; i <= 8; i++) push(4'(i));
    wait_frames(6);
    repeat (20) @(posedge clk);
    for (int i = 0; i < 4; i++) check("b2b_byte", 32'(rx_q[2+i]), 32'(exp_b2b[i]));
    for (int i = 3; i <= 5; i++) check("b2b_gap", 32'(fall_q[i] - fall_q[i-1] - 10*CPB), 32'd3);
    check("b2b_pops", 32'(rd_total - rd0), 32'd8);

    // Reset during data bit 3.
    push(4'h6); push(4'h9);
    t = 0;
    while (fall_q.size() < 7 && t < 1000) begin @(posedge clk); t++; end
    check("abort_frame_started", 32'(fall_q.size()), 32'd7);
    repeat (4*CPB + 4) @(posedge clk);
    #1 check("abort_tx_before", 32'(tx), 32'(1'b0 ^ 1'b0 ^ m_frame[4]));
    #1 rst_n = 1'b0;
    #1;
    check("abort_tx_async", 32'(tx), 32'd1);
    check("abort_busy_async", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push(4'hE); push(4'h7);
    wait_frames(7);
    repeat (20) @(posedge clk);
    check("abort_fresh_byte", 32'(rx_q[6]), 32'h7E);
    check("abort_frame_cnt", 32'(frame_cnt), 32'd1);

    // 255 more frames: the 256th tx_done since reset wraps frame_cnt to 0.
    for (int i = 0; i < 510; i++) push(4'(i));
    t = 0;
    while (done_total < 256 && t < 60000) begin @(posedge clk); t++; end
    check("wrap_done_count", 32'(done_total), 32'd256);
    check("wrap_frame_cnt", 32'(cnt_at_256), 32'd0);
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_nibble_uart_tx.md
Name: fifo_nibble_uart_tx

Overview:
Downstream drain stage for the 4-bit, 8-deep FIFO. It pops nibbles from the FIFO read side and pairs them into bytes, low nibble first. Each byte is sent as a UART 8N1 frame on a single serial pin, so the FIFO contents can leave the chip on one output. It runs on the FIFO read-side clock, with a single clock domain inside the block.

Parameters:
WIDTH, 4, nibble width; byte width is 2*WIDTH (8 at default)
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535

Ports:
clk  input  1  single block clock (FIFO read-side clock)
rst_n  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO empty flag; updates the cycle after a pop
fifo_rdata  input  WIDTH  FIFO head data; valid whenever fifo_empty=0 (show-ahead)
fifo_rd  output  1  pop strobe; head is consumed at the clk edge where fifo_rd=1
tx  output  1  UART serial out; idle high
busy  output  1  high whenever the FSM is not in IDLE
tx_done  output  1  one-cycle pulse after each completed stop bit
frame_cnt  output  8  count of completed frames; wraps 255->0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, tx=1, busy=0, tx_done=0, frame_cnt=0, all internal registers 0.
  - fifo_rd=0 while rst_n=0.
  - A held nibble or partial frame is discarded.
- Outputs: tx, tx_done and frame_cnt are registered. busy is decoded from state.
- fifo_rd is combinational: (state==IDLE or state==WAIT_HI) and !fifo_empty and !rd_q.
  - rd_q is fifo_rd registered.
  - fifo_rd is therefore never high two cycles in a row; this covers the one-cycle flag latency of the FIFO.
- FSM states: IDLE, WAIT_HI, START, DATA, STOP.
  - IDLE: on a fifo_rd cycle, capture fifo_rdata into byte[3:0] and go to WAIT_HI.
  - WAIT_HI: on a fifo_rd cycle, capture fifo_rdata into byte[7:4] and go to START. With the FIFO empty it waits indefinitely: tx=1, busy=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=byte[idx] for CLKS_PER_BIT cycles each, LSB first, idx 0..7. After idx 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- On the IDLE entry cycle after STOP: tx_done=1 and frame_cnt increments, modulo 256.
- Bit timer: counter of width clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1. It reloads at every bit boundary.
- Latency: the tx falling edge (start bit) comes in the cycle after the high-nibble pop.
- Frame length: 10*CLKS_PER_BIT cycles from the start-bit edge to the end of the stop bit.
- Back-to-back with a non-empty FIFO, counting from the last stop-bit cycle t:
  - t+1: low pop, tx_done.
  - t+2: gap cycle (rd_q=1).
  - t+3: high pop.
  - t+4: start bit.
  - Result: exactly 3 extra idle-high cycles between frames.
- The FIFO going empty mid-frame has no effect on the frame in progress. The block reads fifo_empty only in IDLE and WAIT_HI.
- Only two-nibble pairs are sent. There is no timeout flush of an odd trailing nibble.

Test Plan:
- Reset check: rst_n=0 with fifo_empty=0 -> tx=1, busy=0, fifo_rd=0, tx_done=0, frame_cnt=0 throughout reset.
- Single frame (CLKS_PER_BIT=16): FIFO holds 0x5 then 0xA -> byte 0xA5.
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each exactly 16 cycles.
  - Exactly one tx_done pulse; frame_cnt=1.
  - Exactly 2 fifo_rd pulses.
- Odd nibble stall: push 0x3 only and hold the FIFO empty for 100 cycles -> busy=1, tx=1, no start bit. Then push 0xC -> byte 0xC3 is sent, and the start bit begins 1 cycle after the pop.
- Back-to-back: fill the FIFO with 8 nibbles 0x1..0x8 ->
  - Frames 0x21, 0x43, 0x65, 0x87.
  - Exactly 3 idle-high cycles between each stop end and the next start.
  - fifo_rd never high on consecutive cycles; 8 pops total.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx=1 immediately, without waiting for clk. After release, the next frame is built from two fresh pops; no residue from the aborted byte.
- Counter wrap: send 256 frames -> frame_cnt returns to 0 on the 256th tx_done.
